// File: rtl/serial_bus_pkg.sv
// Shared types and constants for the serial-driven peripheral bus initiator.
package serial_bus_pkg;

    // Bridge sequencer states.
    typedef enum logic [2:0] {
        StIdle,
        StGetData,
        StBusSetup,
        StBusStrobe,
        StBusHold,
        StSend
    } bridge_state_t;

    // Serial receiver states.
    typedef enum logic [1:0] {
        RxHunt,
        RxStart,
        RxData,
        RxStop
    } rx_state_t;

    localparam int unsigned CMD_WRITE_BIT    = 7;
    localparam logic [7:0]  RESP_ACK         = 8'h06;
    localparam logic [7:0]  RESP_NAK         = 8'h15;
    localparam int unsigned DEFAULT_BAUD_DIV = 208;

    // Bits 6:4 of a command byte are reserved and must be zero.
    function automatic logic cmd_is_valid(input logic [7:0] cmd);
        return cmd[6:4] == 3'b000;
    endfunction

endpackage

// File: rtl/serial_rx_8n1.sv
// 8N1 serial receiver: falling-edge start detect, mid-bit sampling, stop check.
module serial_rx_8n1
    import serial_bus_pkg::*;
#(
    parameter int unsigned BAUD_DIV = DEFAULT_BAUD_DIV
) (
    input  logic       cpuclk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       rx_frame_err
);

    localparam int unsigned   BW        = $clog2(BAUD_DIV);
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [BW-1:0] HALF_LAST = BW'(BAUD_DIV / 2 - 1);

    logic          rxd_meta;
    logic          rxd_sync;
    logic          rxd_prev;
    rx_state_t     state;
    logic [BW-1:0] cnt;
    logic [2:0]    bit_idx;

    // Two-flop synchroniser plus one delayed copy for edge detection.
    always_ff @(posedge cpuclk) begin
        if (rst) begin
            rxd_meta <= 1'b1;
            rxd_sync <= 1'b1;
            rxd_prev <= 1'b1;
        end else begin
            rxd_meta <= rxd;
            rxd_sync <= rxd_meta;
            rxd_prev <= rxd_sync;
        end
    end

    // Frame receiver; rx_byte doubles as the shift register.
    always_ff @(posedge cpuclk) begin
        if (rst) begin
            state        <= RxHunt;
            cnt          <= '0;
            bit_idx      <= '0;
            rx_byte      <= '0;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
            case (state)
                RxHunt: begin
                    cnt <= '0;
                    if (rxd_prev && !rxd_sync) begin
                        state <= RxStart;
                    end
                end
                RxStart: begin
                    if (cnt == HALF_LAST) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        // Line back high at mid start bit: treat as a glitch.
                        state   <= rxd_sync ? RxHunt : RxData;
                    end else begin
                        cnt <= cnt + BW'(1);
                    end
                end
                RxData: begin
                    if (cnt == BAUD_LAST) begin
                        cnt     <= '0;
                        rx_byte <= {rxd_sync, rx_byte[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state <= RxStop;
                        end
                    end else begin
                        cnt <= cnt + BW'(1);
                    end
                end
                RxStop: begin
                    if (cnt == BAUD_LAST) begin
                        cnt          <= '0;
                        rx_valid     <= rxd_sync;
                        rx_frame_err <= !rxd_sync;
                        state        <= RxHunt;
                    end else begin
                        cnt <= cnt + BW'(1);
                    end
                end
                default: state <= RxHunt;
            endcase
        end
    end

endmodule

// File: rtl/serial_bus_bridge.sv
// Serial command frames in, peripheral bus read/write cycles out, reply byte back.
module serial_bus_bridge
    import serial_bus_pkg::*;
#(
    parameter int unsigned BAUD_DIV      = DEFAULT_BAUD_DIV,
    parameter int unsigned STROBE_CYC    = 3,
    parameter int unsigned TIMEOUT_BYTES = 10
) (
    input  logic       cpuclk,
    input  logic       rst,
    inout  wire  [7:0] data,
    output logic [3:0] addr,
    output logic       ncs,
    output logic       nwr,
    output logic       nrd,
    input  logic       rxd_serial,
    output logic       txd_serial,
    input  logic       cts_serial,
    output logic       busy,
    output logic       err_overrun
);

    localparam int unsigned   TIMEOUT_CYC  = TIMEOUT_BYTES * 10 * BAUD_DIV;
    localparam int unsigned   BW           = $clog2(BAUD_DIV);
    localparam int unsigned   TW           = $clog2(TIMEOUT_CYC);
    localparam int unsigned   SW           = $clog2(STROBE_CYC + 1);
    localparam logic [BW-1:0] BAUD_LAST    = BW'(BAUD_DIV - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [SW-1:0] STROBE_LAST  = SW'(STROBE_CYC - 1);

    bridge_state_t state;
    logic          is_write;
    logic [7:0]    data_out;
    logic          data_oe;
    logic [7:0]    resp;
    logic [SW-1:0] strobe_cnt;
    logic [TW-1:0] timeout_cnt;
    logic          tx_active;
    logic [3:0]    tx_bit;     // 0 start, 1..8 data, 9 stop
    logic [BW-1:0] tx_cnt;
    logic [7:0]    tx_shift;

    logic [7:0]    rx_byte;
    logic          rx_valid;
    logic          rx_frame_err;

    // Only write cycles drive the bus; data_oe is never set on a read path.
    assign data = data_oe ? data_out : 8'bz;

    serial_rx_8n1 #(
        .BAUD_DIV(BAUD_DIV)
    ) u_rx (
        .cpuclk      (cpuclk),
        .rst         (rst),
        .rxd         (rxd_serial),
        .rx_byte     (rx_byte),
        .rx_valid    (rx_valid),
        .rx_frame_err(rx_frame_err)
    );

    // Command sequencer, bus cycle generator and inline transmitter.
    always_ff @(posedge cpuclk) begin
        if (rst) begin
            state       <= StIdle;
            is_write    <= 1'b0;
            data_out    <= '0;
            data_oe     <= 1'b0;
            resp        <= '0;
            strobe_cnt  <= '0;
            timeout_cnt <= '0;
            tx_active   <= 1'b0;
            tx_bit      <= '0;
            tx_cnt      <= '0;
            tx_shift    <= '0;
            addr        <= '0;
            ncs         <= 1'b1;
            nwr         <= 1'b1;
            nrd         <= 1'b1;
            txd_serial  <= 1'b1;
            busy        <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    if (rx_frame_err) begin
                        state <= StSend;
                        resp  <= RESP_NAK;
                        busy  <= 1'b1;
                    end else if (rx_valid) begin
                        busy <= 1'b1;
                        if (!cmd_is_valid(rx_byte)) begin
                            state <= StSend;
                            resp  <= RESP_NAK;
                        end else begin
                            addr     <= rx_byte[3:0];
                            is_write <= rx_byte[CMD_WRITE_BIT];
                            if (rx_byte[CMD_WRITE_BIT]) begin
                                timeout_cnt <= '0;
                                state       <= StGetData;
                            end else begin
                                state <= StBusSetup;
                            end
                        end
                    end
                end
                StGetData: begin
                    timeout_cnt <= timeout_cnt + TW'(1);
                    if (rx_valid) begin
                        data_out <= rx_byte;
                        data_oe  <= 1'b1;
                        state    <= StBusSetup;
                    end else if (rx_frame_err || timeout_cnt == TIMEOUT_LAST) begin
                        state <= StSend;
                        resp  <= RESP_NAK;
                    end
                end
                StBusSetup: begin
                    ncs        <= 1'b0;
                    nwr        <= !is_write;
                    nrd        <= is_write;
                    strobe_cnt <= '0;
                    state      <= StBusStrobe;
                end
                StBusStrobe: begin
                    strobe_cnt <= strobe_cnt + SW'(1);
                    if (strobe_cnt == STROBE_LAST) begin
                        ncs   <= 1'b1;
                        nwr   <= 1'b1;
                        nrd   <= 1'b1;
                        resp  <= is_write ? RESP_ACK : data;
                        state <= StBusHold;
                    end
                end
                StBusHold: begin
                    data_oe <= 1'b0;
                    state   <= StSend;
                end
                StSend: begin
                    if (!tx_active) begin
                        // cts gates only the start bit; later changes are ignored.
                        if (!cts_serial) begin
                            tx_active  <= 1'b1;
                            txd_serial <= 1'b0;
                            tx_cnt     <= '0;
                            tx_bit     <= '0;
                            tx_shift   <= resp;
                        end
                    end else if (tx_cnt == BAUD_LAST) begin
                        tx_cnt <= '0;
                        tx_bit <= tx_bit + 4'd1;
                        if (tx_bit == 4'd9) begin
                            tx_active <= 1'b0;
                            busy      <= 1'b0;
                            state     <= StIdle;
                        end else if (tx_bit == 4'd8) begin
                            txd_serial <= 1'b1;
                        end else begin
                            txd_serial <= tx_shift[0];
                            tx_shift   <= {1'b0, tx_shift[7:1]};
                        end
                    end else begin
                        tx_cnt <= tx_cnt + BW'(1);
                    end
                end
                default: state <= StIdle;
            endcase

            if (rx_valid && (state inside {StBusSetup, StBusStrobe, StBusHold, StSend})) begin
                err_overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_serial_bus_bridge.sv
// Directed bench for serial_bus_bridge: serial stimulus, bus model, reply decoding.
`timescale 1ns/1ps
module tb_serial_bus_bridge;

    localparam int BAUD = 208;
    localparam int LIM  = 8000;

    logic       cpuclk = 1'b0;
    logic       rst;
    wire  [7:0] data;
    logic [3:0] addr;
    logic       ncs;
    logic       nwr;
    logic       nrd;
    logic       rxd_serial;
    logic       txd_serial;
    logic       cts_serial;
    logic       busy;
    logic       err_overrun;

    int checks = 0;
    int errors = 0;

    // Bus monitor state
    logic       mon_clr = 1'b0;
    logic       nwr_prev = 1'b1;
    int         ncs_cnt, nwr_cnt, nrd_cnt, wr_edges, oe_viol;
    logic [7:0] wr_data;
    logic [3:0] wr_addr, rd_addr;

    serial_bus_bridge dut (
        .cpuclk     (cpuclk),
        .rst        (rst),
        .data       (data),
        .addr       (addr),
        .ncs        (ncs),
        .nwr        (nwr),
        .nrd        (nrd),
        .rxd_serial (rxd_serial),
        .txd_serial (txd_serial),
        .cts_serial (cts_serial),
        .busy       (busy),
        .err_overrun(err_overrun)
    );

    always #5 cpuclk = ~cpuclk;

    function automatic logic [7:0] bus_rd(input logic [3:0] a);
        case (a)
            4'h8:    return 8'h02;
            4'h9:    return 8'hC3;
            default: return 8'hEE;
        endcase
    endfunction

    // Peripheral model answers reads only while selected and strobed.
    assign data = (!ncs && !nrd) ? bus_rd(addr) : 8'bz;

    always @(negedge cpuclk) begin
        if (mon_clr) begin
            ncs_cnt  <= 0;
            nwr_cnt  <= 0;
            nrd_cnt  <= 0;
            wr_edges <= 0;
            oe_viol  <= 0;
            wr_data  <= '0;
            wr_addr  <= '0;
            rd_addr  <= '0;
        end else begin
            if (!ncs) ncs_cnt <= ncs_cnt + 1;
            if (!nwr) begin
                nwr_cnt <= nwr_cnt + 1;
                wr_addr <= addr;
                wr_data <= data;
            end
            if (!nwr && nwr_prev) wr_edges <= wr_edges + 1;
            if (!nrd) begin
                nrd_cnt <= nrd_cnt + 1;
                rd_addr <= addr;
                if (dut.data_oe) oe_viol <= oe_viol + 1;
            end
        end
        nwr_prev <= nwr;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        @(posedge cpuclk);
        #1 mon_clr = 1'b1;
        @(posedge cpuclk);
        #1 mon_clr = 1'b0;
        @(negedge cpuclk);
    endtask

    task automatic send_byte(input logic [7:0] b, input int stop_cycles);
        rxd_serial = 1'b0;
        repeat (BAUD) @(negedge cpuclk);
        for (int i = 0; i < 8; i++) begin
            rxd_serial = b[i];
            repeat (BAUD) @(negedge cpuclk);
        end
        rxd_serial = 1'b1;
        repeat (stop_cycles) @(negedge cpuclk);
    endtask

    task automatic recv_byte(input int limit, output logic [7:0] b, output logic ok,
                             output int waited);
        ok = 1'b1;
        b = '0;
        waited = 0;
        while (txd_serial !== 1'b0 && waited < limit) begin
            @(negedge cpuclk);
            waited++;
        end
        if (txd_serial !== 1'b0) begin
            ok = 1'b0;
        end else begin
            repeat (BAUD / 2) @(negedge cpuclk);
            if (txd_serial !== 1'b0) ok = 1'b0;
            for (int i = 0; i < 8; i++) begin
                repeat (BAUD) @(negedge cpuclk);
                b[i] = txd_serial;
            end
            repeat (BAUD) @(negedge cpuclk);
            if (txd_serial !== 1'b1) ok = 1'b0;
        end
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] rb;
        logic       ok;
        int         w;
        int         n;
        int         tx_low;

        rst        = 1'b1;
        rxd_serial = 1'b1;
        cts_serial = 1'b0;
        repeat (3) @(negedge cpuclk);
        check_eq("rst_txd", txd_serial, 1);
        check_eq("rst_ncs", ncs, 1);
        check_eq("rst_nwr", nwr, 1);
        check_eq("rst_nrd", nrd, 1);
        check_eq("rst_addr", addr, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_ovr", err_overrun, 0);
        rst = 1'b0;
        repeat (5) @(negedge cpuclk);

        // Write 0x5A to register 9
        clear_mon();
        send_byte(8'h89, BAUD);
        fork
            send_byte(8'h5A, BAUD / 2);
            recv_byte(LIM, rb, ok, w);
        join
        check_eq("wr_rx_ok", ok, 1);
        check_eq("wr_reply", rb, 8'h06);
        check_eq("wr_busy_stop", busy, 1);
        repeat (BAUD / 2 + 2) @(negedge cpuclk);
        check_eq("wr_busy_end", busy, 0);
        check_eq("wr_ncs_cyc", ncs_cnt, 3);
        check_eq("wr_nwr_cyc", nwr_cnt, 3);
        check_eq("wr_edges", wr_edges, 1);
        check_eq("wr_nrd_cyc", nrd_cnt, 0);
        check_eq("wr_addr", wr_addr, 4'h9);
        check_eq("wr_data", wr_data, 8'h5A);

        // Read register 8
        clear_mon();
        fork
            send_byte(8'h08, BAUD / 2);
            recv_byte(LIM, rb, ok, w);
        join
        check_eq("rd_rx_ok", ok, 1);
        check_eq("rd_reply", rb, 8'h02);
        check_eq("rd_nrd_cyc", nrd_cnt, 3);
        check_eq("rd_ncs_cyc", ncs_cnt, 3);
        check_eq("rd_nwr_cyc", nwr_cnt, 0);
        check_eq("rd_addr", rd_addr, 4'h8);
        check_eq("rd_no_drive", oe_viol, 0);
        repeat (BAUD / 2 + 2) @(negedge cpuclk);

        // Reserved bits set: NAK with no bus activity
        clear_mon();
        fork
            send_byte(8'h38, BAUD / 2);
            recv_byte(LIM, rb, ok, w);
        join
        check_eq("inv_rx_ok", ok, 1);
        check_eq("inv_reply", rb, 8'h15);
        check_eq("inv_ncs_cyc", ncs_cnt, 0);
        repeat (BAUD / 2 + 2) @(negedge cpuclk);
        check_eq("inv_busy_end", busy, 0);

        // Write command with no data byte: timeout after 10 byte-times
        clear_mon();
        send_byte(8'h81, BAUD);
        recv_byte(30000, rb, ok, w);
        check_eq("to_rx_ok", ok, 1);
        check_eq("to_reply", rb, 8'h15);
        check_eq("to_window", (w >= 20500 && w <= 20900), 1);
        check_eq("to_ncs_cyc", ncs_cnt, 0);
        repeat (BAUD / 2 + 2) @(negedge cpuclk);
        check_eq("to_busy_end", busy, 0);

        // Flow control and overrun
        cts_serial = 1'b1;
        clear_mon();
        send_byte(8'h09, BAUD / 2);
        repeat (20) @(negedge cpuclk);
        check_eq("fc_nrd_cyc", nrd_cnt, 3);
        check_eq("fc_busy", busy, 1);
        tx_low = 0;
        fork
            send_byte(8'h55, BAUD);
            for (int i = 0; i < 2300; i++) begin
                @(negedge cpuclk);
                if (txd_serial !== 1'b1) tx_low++;
            end
        join
        check_eq("fc_txd_held", tx_low, 0);
        check_eq("fc_overrun", err_overrun, 1);
        cts_serial = 1'b0;
        n = 0;
        while (txd_serial !== 1'b0 && n < 10) begin
            @(negedge cpuclk);
            n++;
        end
        check_eq("fc_start_lat", n, 1);
        recv_byte(LIM, rb, ok, w);
        check_eq("fc_rx_ok", ok, 1);
        check_eq("fc_reply", rb, 8'hC3);
        repeat (BAUD / 2 + 2) @(negedge cpuclk);
        check_eq("fc_busy_end", busy, 0);

        // Reset during the strobe of a write
        clear_mon();
        send_byte(8'h83, BAUD);
        fork
            send_byte(8'hA5, BAUD / 2);
            begin
                n = 0;
                while (nwr !== 1'b0 && n < LIM) begin
                    @(negedge cpuclk);
                    n++;
                end
                check_eq("rs_strobe_seen", nwr, 0);
                rst = 1'b1;
                @(negedge cpuclk);
                check_eq("rs_ncs", ncs, 1);
                check_eq("rs_nwr", nwr, 1);
                check_eq("rs_busy", busy, 0);
                check_eq("rs_data_rel", dut.data_oe, 0);
                check_eq("rs_ovr_clr", err_overrun, 0);
                check_eq("rs_txd", txd_serial, 1);
                rst = 1'b0;
            end
        join
        repeat (10) @(negedge cpuclk);
        clear_mon();
        fork
            send_byte(8'h08, BAUD / 2);
            recv_byte(LIM, rb, ok, w);
        join
        check_eq("rs_rd_ok", ok, 1);
        check_eq("rs_rd_reply", rb, 8'h02);
        check_eq("rs_rd_nrd", nrd_cnt, 3);
        repeat (BAUD / 2 + 2) @(negedge cpuclk);
        check_eq("rs_busy_end", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
